// File: rtl/col_collector.sv
// col_collector: collects ROW-bit column vectors into a ROW x WIDTH buffer, then streams it out as ROW row words.
// Optional partial-buffer drain (flush port) is enabled by defining COL_FLUSH_EN.
module col_collector #(
  parameter int unsigned ROW       = 16,
  parameter int unsigned WIDTH     = 128,
  parameter int unsigned LOG_WIDTH = 7,
  parameter int unsigned LOG_ROW   = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 col_valid,
  output logic                 col_ready,
  input  logic [ROW-1:0]       col_data,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic [WIDTH-1:0]     word_data,
  output logic [LOG_ROW-1:0]   word_idx,
  output logic                 busy
`ifdef COL_FLUSH_EN
  ,
  input  logic                 flush
`endif
);

  localparam logic [0:0] S_FILL  = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [LOG_WIDTH-1:0] col_cnt_q, col_cnt_d;
  logic [LOG_ROW-1:0]   row_cnt_q, row_cnt_d;
  logic [WIDTH-1:0]     col_mask_q, col_mask_d;
  logic                 col_ready_q, word_valid_q;
  logic [WIDTH-1:0]     store_q [ROW];

  logic col_fire;
  logic word_fire;
  logic flush_req;

  assign col_fire  = col_valid && col_ready_q;
  assign word_fire = word_valid_q && word_ready;

`ifdef COL_FLUSH_EN
  // A non-empty buffer always implies FILL, so col_cnt alone qualifies the flush.
  assign flush_req = flush && (col_cnt_q != '0);
`else
  assign flush_req = 1'b0;
`endif

  // Next-state logic for the fill/drain sequencer.
  always_comb begin
    state_d    = state_q;
    col_cnt_d  = col_cnt_q;
    row_cnt_d  = row_cnt_q;
    col_mask_d = col_mask_q;
    case (state_q)
      S_FILL: begin
        if (col_fire) begin
          col_mask_d[col_cnt_q] = 1'b1;
          col_cnt_d             = col_cnt_q + LOG_WIDTH'(1);
          if (col_cnt_q == LOG_WIDTH'(WIDTH - 1)) begin
            col_cnt_d = '0;
            state_d   = S_DRAIN;
          end
        end
        if (flush_req) begin
          col_cnt_d = '0;
          state_d   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (word_fire) begin
          row_cnt_d = row_cnt_q + LOG_ROW'(1);
          if (row_cnt_q == LOG_ROW'(ROW - 1)) begin
            row_cnt_d  = '0;
            col_mask_d = '0;
            state_d    = S_FILL;
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  // Control registers; handshake flags are registered copies of the next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_FILL;
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      col_mask_q   <= '0;
      col_ready_q  <= 1'b0;
      word_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      col_mask_q   <= col_mask_d;
      col_ready_q  <= (state_d == S_FILL);
      word_valid_q <= (state_d == S_DRAIN);
    end
  end

  // Transpose storage: column k lands in bit k of every row; contents survive reset.
  always_ff @(posedge clk) begin
    if (col_fire) begin
      for (int j = 0; j < ROW; j++) begin
        store_q[j][col_cnt_q] <= col_data[j];
      end
    end
  end

  assign col_ready  = col_ready_q;
  assign word_valid = word_valid_q;
  assign word_idx   = row_cnt_q;
  assign word_data  = word_valid_q ? (store_q[row_cnt_q] & col_mask_q) : '0;
  assign busy       = (col_cnt_q != '0) || (state_q == S_DRAIN);

endmodule

// File: tb/tb_col_collector.sv
// Testbench for col_collector: table-driven buffers, reset/backpressure/gap sequences and
// randomized traffic checked against a transpose scoreboard.
module tb_col_collector;

  logic         clk;
  logic         rstn;
  logic         col_valid;
  logic         col_ready;
  logic [15:0]  col_data;
  logic         word_valid;
  logic         word_ready;
  logic [127:0] word_data;
  logic [3:0]   word_idx;
  logic         busy;
`ifdef COL_FLUSH_EN
  logic         flush;
`endif

  col_collector dut (
    .clk        (clk),
    .rstn       (rstn),
    .col_valid  (col_valid),
    .col_ready  (col_ready),
    .col_data   (col_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data),
    .word_idx   (word_idx),
    .busy       (busy)
`ifdef COL_FLUSH_EN
    ,
    .flush      (flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model: accepted columns -> transposed words ----------------
  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] data;
  } word_t;

  word_t        exp_q[$];
  logic [15:0]  cols[$];
  logic [127:0] got_w [16];
  int           n_before;
  word_t        w_exp;
  word_t        w_new;
  bit           flush_seen;

  always @(negedge clk) begin
    if (!rstn) begin
      cols.delete();
      exp_q.delete();
    end else begin
      n_before = cols.size();
      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 128'(word_idx), 128'hDEAD);
        end else begin
          w_exp = exp_q.pop_front();
          chk("sb_word_idx", 128'(word_idx), 128'(w_exp.idx));
          chk("sb_word_data", word_data, w_exp.data);
        end
        got_w[word_idx] = word_data;
      end
      if (!word_valid) chk("idle_data_zero", word_data, 128'h0);
      if (col_valid && col_ready) cols.push_back(col_data);
      flush_seen = 1'b0;
`ifdef COL_FLUSH_EN
      flush_seen = flush && (n_before > 0);
`endif
      if (cols.size() == 128 || flush_seen) begin
        for (int i = 0; i < 16; i++) begin
          w_new.idx  = 4'(i);
          w_new.data = '0;
          for (int k = 0; k < cols.size(); k++) w_new.data[k] = cols[k][i];
          exp_q.push_back(w_new);
        end
        cols.delete();
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [15:0] col_of(input int kind, input int k);
    case (kind)
      0:       col_of = 16'h0001 << (k % 16);
      1:       col_of = 16'hFFFF;
      2:       col_of = 16'h0000;
      3:       col_of = (k < 64) ? 16'hFFFF : 16'h0000;
      4:       col_of = (k % 2 == 1) ? 16'h0021 : 16'h0000;
      default: col_of = 16'($urandom);
    endcase
  endfunction

  task automatic send_col(input logic [15:0] d);
    bit ok;
    ok        = 1'b0;
    col_valid = 1'b1;
    col_data  = d;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (col_ready) begin
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    col_valid = 1'b0;
    if (!ok) chk("col_accept_timeout", 128'(0), 128'(1));
  endtask

  // Fills one buffer, optionally stalls the first word, drains and reports col_ready-low cycles.
  task automatic run_buffer(input int kind, input bit gaps, input int stall, output int ready_low);
    logic [127:0] first_w;
    bit           done;
    for (int i = 0; i < 16; i++) got_w[i] = '0;
    word_ready = (stall == 0);
    for (int k = 0; k < 128; k++) begin
      send_col(col_of(kind, k));
      if (gaps && k != 127) begin
        @(posedge clk); #1;
      end
    end
    ready_low = 0;
    @(negedge clk);
    chk("drain_latency_valid", 128'(word_valid), 128'(1));
    first_w = word_data;
    for (int s = 0; s < stall; s++) begin
      chk("stall_valid", 128'(word_valid), 128'(1));
      chk("stall_idx", 128'(word_idx), 128'(0));
      chk("stall_data_stable", word_data, first_w);
      chk("stall_col_ready", 128'(col_ready), 128'(0));
      ready_low++;
      @(posedge clk); #1;
      if (s == stall - 1) word_ready = 1'b1;
      @(negedge clk);
    end
    done = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (col_ready) begin
        done = 1'b1;
        break;
      end
      ready_low++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    if (!done) chk("drain_timeout", 128'(0), 128'(1));
    @(posedge clk); #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int           kind;
    bit           gaps;
    int           stall;
    logic [127:0] w0;
    logic [127:0] w1;
    logic [127:0] w5;
    int           low;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int low;
    int sent;
    bit acc;

    vecs[0] = '{0, 1'b0, 0,  {8{16'h0001}}, {8{16'h0002}}, {8{16'h0020}}, 16};
    vecs[1] = '{0, 1'b0, 10, {8{16'h0001}}, {8{16'h0002}}, {8{16'h0020}}, 26};
    vecs[2] = '{4, 1'b1, 0,  {8{16'hAAAA}}, 128'h0,        {8{16'hAAAA}}, 16};
    vecs[3] = '{1, 1'b0, 0,  {128{1'b1}},   {128{1'b1}},   {128{1'b1}},   16};
    vecs[4] = '{2, 1'b0, 0,  128'h0,        128'h0,        128'h0,        16};
    vecs[5] = '{3, 1'b0, 3,  {64'h0, {64{1'b1}}}, {64'h0, {64{1'b1}}}, {64'h0, {64{1'b1}}}, 19};

    rstn       = 1'b1;
    col_valid  = 1'b0;
    col_data   = '0;
    word_ready = 1'b0;
`ifdef COL_FLUSH_EN
    flush      = 1'b0;
`endif
    #3 rstn = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_col_ready", 128'(col_ready), 128'(0));
    chk("rst_word_valid", 128'(word_valid), 128'(0));
    chk("rst_word_data", word_data, 128'h0);
    chk("rst_word_idx", 128'(word_idx), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    @(posedge clk); #1 rstn = 1'b1;

    // Reset mid-FILL after 5 columns discards the partial buffer
    for (int k = 0; k < 5; k++) send_col(16'hBEEF);
    @(negedge clk);
    chk("fill_busy", 128'(busy), 128'(1));
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("midrst_word_valid", 128'(word_valid), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_col_ready", 128'(col_ready), 128'(0));
    @(posedge clk); #1 rstn = 1'b1;

    // Table-driven buffers (entries 3 and 4 run back-to-back)
    foreach (vecs[v]) begin
      run_buffer(vecs[v].kind, vecs[v].gaps, vecs[v].stall, low);
      chk($sformatf("vec%0d_word0", v), got_w[0], vecs[v].w0);
      chk($sformatf("vec%0d_word1", v), got_w[1], vecs[v].w1);
      chk($sformatf("vec%0d_word5", v), got_w[5], vecs[v].w5);
      chk($sformatf("vec%0d_ready_low", v), 128'(low), 128'(vecs[v].low));
      chk($sformatf("vec%0d_sb_empty", v), 128'(exp_q.size()), 128'(0));
    end

    // Randomized traffic: 4 buffers with random valid gaps and word_ready backpressure
    sent       = 0;
    word_ready = 1'b0;
    col_valid  = 1'b0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (sent == 512 && exp_q.size() == 0 && !word_valid) break;
      @(negedge clk);
      acc = col_valid && col_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      if (!col_valid || acc) begin
        col_valid = (sent < 512) && ($urandom_range(0, 2) != 0);
        col_data  = 16'($urandom);
      end
      word_ready = ($urandom_range(0, 3) != 0);
    end
    col_valid  = 1'b0;
    word_ready = 1'b0;
    chk("rand_cols_sent", 128'(sent), 128'(512));
    chk("rand_sb_empty", 128'(exp_q.size()), 128'(0));

`ifdef COL_FLUSH_EN
    // Flush with an empty buffer is ignored
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_empty_valid", 128'(word_valid), 128'(0));
    chk("flush_empty_busy", 128'(busy), 128'(0));
    chk("flush_empty_ready", 128'(col_ready), 128'(1));
    @(posedge clk); #1;

    // Three columns then flush: unwritten columns read as zero
    for (int i = 0; i < 16; i++) got_w[i] = '0;
    for (int k = 0; k < 3; k++) send_col(16'hFFFF);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_drain_valid", 128'(word_valid), 128'(1));
    @(posedge clk); #1;
    word_ready = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (col_ready) break;
      @(posedge clk); #1;
    end
    chk("flush_word0", got_w[0], 128'h7);
    chk("flush_word15", got_w[15], 128'h7);
    chk("flush_sb_empty", 128'(exp_q.size()), 128'(0));
    word_ready = 1'b0;
`endif

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
